// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the CPU MEM stage and a
// debug/loader port. The debug port goes through a three-state FSM
// (D_IDLE -> D_PEND -> D_ACK). While a debug access is pending, the CPU
// keeps priority for at most STARVE_LIMIT consecutive grants.
// Optional build macro: MEM_ARB_PERF_CNT_EN enables the CPU stall-cycle counter.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_stall,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout,
    output logic [15:0] cpu_stall_cnt
);

    localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        D_IDLE,
        D_PEND,
        D_ACK
    } dbg_state_t;

    dbg_state_t    state;
    logic [CW-1:0] starve_cnt;
    logic          lat_we;
    logic [7:0]    lat_addr;
    logic [7:0]    lat_wdata;
    logic [7:0]    dbg_rdata_q;
    logic [7:0]    cpu_rdata_q;
    logic          dbg_grant;
    logic          cpu_grant;

    // Per-cycle arbitration; everything is gated off while reset is asserted.
    always_comb begin
        dbg_grant = rst && (state == D_PEND) && (!cpu_req || (starve_cnt == LIMIT));
        cpu_grant = rst && cpu_req && !dbg_grant;
        cpu_stall = rst && cpu_req && !cpu_grant;
    end

    // RAM port mux: debug from latched fields, else CPU, else quiet (all zero).
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (dbg_grant) begin
            ram_we   = lat_we;
            ram_addr = lat_addr;
            ram_din  = lat_wdata;
        end else if (cpu_grant) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
        end
    end

    // Debug FSM: latch request, wait for grant (bounded by starve counter), ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= D_IDLE;
            starve_cnt  <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            dbg_ack     <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            case (state)
                D_IDLE: begin
                    dbg_ack <= 1'b0;
                    if (dbg_req) begin
                        lat_we     <= dbg_we;
                        lat_addr   <= dbg_addr;
                        lat_wdata  <= dbg_wdata;
                        starve_cnt <= '0;
                        state      <= D_PEND;
                    end
                end
                D_PEND: begin
                    if (dbg_grant) begin
                        starve_cnt <= '0;
                        dbg_ack    <= 1'b1;
                        state      <= D_ACK;
                    end else if (cpu_grant && (starve_cnt != LIMIT)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                D_ACK: begin
                    dbg_ack     <= 1'b0;
                    dbg_rdata_q <= lat_we ? 8'h00 : ram_dout;
                    state       <= D_IDLE;
                end
                default: begin
                    dbg_ack <= 1'b0;
                    state   <= D_IDLE;
                end
            endcase
        end
    end

    // RAM data only arrives in the ack cycle, so it is passed straight through
    // then and held in dbg_rdata_q afterwards to keep the output stable.
    always_comb begin
        if (dbg_ack) begin
            dbg_rdata = lat_we ? 8'h00 : ram_dout;
        end else begin
            dbg_rdata = dbg_rdata_q;
        end
    end

    // CPU read-valid tracking and read-data hold register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rvalid  <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            cpu_rvalid <= cpu_grant && !cpu_we;
            if (cpu_rvalid) begin
                cpu_rdata_q <= ram_dout;
            end
        end
    end

    // Same pass-through/hold scheme as the debug read data.
    always_comb begin
        cpu_rdata = cpu_rvalid ? ram_dout : cpu_rdata_q;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles the CPU was held off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign cpu_stall_cnt = stall_cnt_q;
`else
    assign cpu_stall_cnt = '0;
`endif

endmodule
